// File: rtl/controle_deslocamento.sv
// controle_deslocamento: multi-cycle shift sequencer for the processor datapath.
//
// Accepts one request (operand, amount, type) through a valid/ready handshake.
// It then shifts an internal register by one bit per clock until the amount is
// used up, and presents the result with a one-cycle valid pulse. The ALU control
// uses it for SLL/SRL/SRA/ROL instead of a combinational barrel shifter.
//
// Ports:
//   clock_i            rising-edge clock
//   reset_i            synchronous active-low reset
//   req_valido_i       request present this cycle
//   req_pronto_o       block can accept a request
//   operando_i         value to shift, sampled on accept
//   quantidade_i       shift amount, sampled on accept
//   tipo_i             00 SLL, 01 SRL, 10 SRA, 11 ROL; sampled on accept
//   resultado_o        shift register contents (final only when valid pulses)
//   resultado_valido_o one-cycle pulse: resultado_o is final
//   ocupado_o          high while shifting or presenting the result

module controle_deslocamento #(
  parameter int unsigned LARGURA     = 32,
  parameter int unsigned LARGURA_QTD = 5
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   req_valido_i,
  output logic                   req_pronto_o,
  input  logic [LARGURA-1:0]     operando_i,
  input  logic [LARGURA_QTD-1:0] quantidade_i,
  input  logic [1:0]             tipo_i,
  output logic [LARGURA-1:0]     resultado_o,
  output logic                   resultado_valido_o,
  output logic                   ocupado_o
);

  localparam logic [1:0] StOcioso     = 2'd0;
  localparam logic [1:0] StDeslocando = 2'd1;
  localparam logic [1:0] StConcluido  = 2'd2;

  localparam logic [1:0] TipoSll = 2'b00;
  localparam logic [1:0] TipoSrl = 2'b01;
  localparam logic [1:0] TipoSra = 2'b10;
  localparam logic [1:0] TipoRol = 2'b11;

  localparam logic [LARGURA_QTD-1:0] QtdZero = '0;
  localparam logic [LARGURA_QTD-1:0] QtdUm   = LARGURA_QTD'(1);

  logic [1:0]             estado_q, estado_d;
  logic [LARGURA-1:0]     reg_q, reg_d;
  logic [LARGURA_QTD-1:0] cont_q, cont_d;
  logic [1:0]             tipo_q, tipo_d;

  logic                   aceita;
  logic [LARGURA-1:0]     reg_deslocado;

  // Ready is masked by reset so nothing is accepted on the same edge that resets.
  assign req_pronto_o = (estado_q == StOcioso) & reset_i;
  assign aceita       = req_valido_i & req_pronto_o;

  // One-bit shift of the working register according to the latched type.
  always_comb begin
    reg_deslocado = reg_q;
    case (tipo_q)
      TipoSll: reg_deslocado = {reg_q[LARGURA-2:0], 1'b0};
      TipoSrl: reg_deslocado = {1'b0, reg_q[LARGURA-1:1]};
      TipoSra: reg_deslocado = {reg_q[LARGURA-1], reg_q[LARGURA-1:1]};
      TipoRol: reg_deslocado = {reg_q[LARGURA-2:0], reg_q[LARGURA-1]};
      default: reg_deslocado = reg_q;
    endcase
  end

  always_comb begin
    estado_d = estado_q;
    reg_d    = reg_q;
    cont_d   = cont_q;
    tipo_d   = tipo_q;
    case (estado_q)
      StOcioso: begin
        if (aceita) begin
          reg_d  = operando_i;
          cont_d = quantidade_i;
          tipo_d = tipo_i;
          estado_d = (quantidade_i == QtdZero) ? StConcluido : StDeslocando;
        end
      end
      StDeslocando: begin
        reg_d  = reg_deslocado;
        cont_d = cont_q - QtdUm;
        // Last shift happens on this edge; the counter reaches 0, never wraps.
        if (cont_q == QtdUm) begin
          estado_d = StConcluido;
        end
      end
      StConcluido: begin
        estado_d = StOcioso;
      end
      default: begin
        estado_d = StOcioso;
      end
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      estado_q <= StOcioso;
      reg_q    <= '0;
      cont_q   <= '0;
      tipo_q   <= '0;
    end else begin
      estado_q <= estado_d;
      reg_q    <= reg_d;
      cont_q   <= cont_d;
      tipo_q   <= tipo_d;
    end
  end

  assign resultado_o        = reg_q;
  assign resultado_valido_o = (estado_q == StConcluido);
  assign ocupado_o          = (estado_q == StDeslocando) | (estado_q == StConcluido);

endmodule

// File: tb/tb_controle_deslocamento.sv
// Directed testbench for controle_deslocamento: a table of single jobs with
// hand-computed results, plus sequences for reset, mid-job abort, requests held
// during a job, and back-to-back jobs. Inputs change and outputs are sampled
// on the falling edge.

module tb_controle_deslocamento;

  logic        clock_i;
  logic        reset_i;
  logic        req_valido_i;
  logic        req_pronto_o;
  logic [31:0] operando_i;
  logic [4:0]  quantidade_i;
  logic [1:0]  tipo_i;
  logic [31:0] resultado_o;
  logic        resultado_valido_o;
  logic        ocupado_o;

  int n_cmp = 0;
  int n_err = 0;

  controle_deslocamento #(
    .LARGURA    (32),
    .LARGURA_QTD(5)
  ) dut (
    .clock_i           (clock_i),
    .reset_i           (reset_i),
    .req_valido_i      (req_valido_i),
    .req_pronto_o      (req_pronto_o),
    .operando_i        (operando_i),
    .quantidade_i      (quantidade_i),
    .tipo_i            (tipo_i),
    .resultado_o       (resultado_o),
    .resultado_valido_o(resultado_valido_o),
    .ocupado_o         (ocupado_o)
  );

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  typedef struct {
    logic [1:0]  tipo;
    logic [31:0] op;
    logic [4:0]  qtd;
    logic [31:0] esp;
  } vec_t;

  vec_t tab[11];

  task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    n_cmp++;
    if (atual !== esperado) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", nome, atual, esperado);
    end
  endtask

  // Runs one job from idle; tipo_i is flipped after accept to show it is latched.
  task automatic job(input int idx, input logic [1:0] tipo, input logic [31:0] op,
                     input logic [4:0] qtd, input logic [31:0] esp);
    int w;
    @(negedge clock_i);
    chk($sformatf("v%0d pronto", idx), {31'd0, req_pronto_o}, 32'd1);
    req_valido_i = 1'b1;
    operando_i   = op;
    quantidade_i = qtd;
    tipo_i       = tipo;
    @(negedge clock_i);
    req_valido_i = 1'b0;
    tipo_i       = ~tipo;
    operando_i   = 32'hA5A5A5A5;
    w = 0;
    while (!resultado_valido_o && w < 64) begin
      @(negedge clock_i);
      w++;
    end
    chk($sformatf("v%0d latency", idx), 32'(w), 32'(qtd));
    chk($sformatf("v%0d resultado", idx), resultado_o, esp);
    chk($sformatf("v%0d ocupado", idx), {31'd0, ocupado_o}, 32'd1);
    @(negedge clock_i);
    chk($sformatf("v%0d pulse end", idx), {31'd0, resultado_valido_o}, 32'd0);
    chk($sformatf("v%0d idle ocupado", idx), {31'd0, ocupado_o}, 32'd0);
    chk($sformatf("v%0d hold", idx), resultado_o, esp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tab[0]  = '{2'b00, 32'h00000004, 5'd2,  32'h00000010};
    tab[1]  = '{2'b10, 32'h80000000, 5'd4,  32'hF8000000};
    tab[2]  = '{2'b01, 32'h80000000, 5'd31, 32'h00000001};
    tab[3]  = '{2'b10, 32'h12345678, 5'd0,  32'h12345678};
    tab[4]  = '{2'b11, 32'h80000001, 5'd1,  32'h00000003};
    tab[5]  = '{2'b00, 32'h00000001, 5'd31, 32'h80000000};
    tab[6]  = '{2'b10, 32'h7FFFFFFF, 5'd31, 32'h00000000};
    tab[7]  = '{2'b11, 32'h12345678, 5'd4,  32'h23456781};
    tab[8]  = '{2'b01, 32'hF0F0F0F0, 5'd8,  32'h00F0F0F0};
    tab[9]  = '{2'b10, 32'h80000001, 5'd31, 32'hFFFFFFFF};
    tab[10] = '{2'b11, 32'hDEADBEEF, 5'd31, 32'hEF56DF77};

    reset_i      = 1'b0;
    req_valido_i = 1'b0;
    operando_i   = 32'hFFFFFFFF;
    quantidade_i = 5'd0;
    tipo_i       = 2'b00;

    // Reset state; a request held during reset must not be taken.
    @(negedge clock_i);
    req_valido_i = 1'b1;
    @(negedge clock_i);
    chk("rst resultado", resultado_o, 32'h0);
    chk("rst valido", {31'd0, resultado_valido_o}, 32'd0);
    chk("rst ocupado", {31'd0, ocupado_o}, 32'd0);
    chk("rst pronto", {31'd0, req_pronto_o}, 32'd0);
    req_valido_i = 1'b0;
    reset_i      = 1'b1;
    #1;
    chk("rst release pronto", {31'd0, req_pronto_o}, 32'd1);

    for (int i = 0; i < 11; i++) begin
      job(i, tab[i].tipo, tab[i].op, tab[i].qtd, tab[i].esp);
    end

    // ROL by 1 with req_valido kept high: the second request (SLL 4 by 2) waits
    // for the idle cycle, is accepted at its end, and tipo change after the
    // first accept must not turn the ROL into an SLL.
    @(negedge clock_i);
    req_valido_i = 1'b1;
    operando_i   = 32'h80000001;
    quantidade_i = 5'd1;
    tipo_i       = 2'b11;
    @(negedge clock_i);
    operando_i   = 32'h00000004;
    quantidade_i = 5'd2;
    tipo_i       = 2'b00;
    chk("b2b busy pronto", {31'd0, req_pronto_o}, 32'd0);
    chk("b2b busy valido", {31'd0, resultado_valido_o}, 32'd0);
    @(negedge clock_i);
    chk("b2b first valido", {31'd0, resultado_valido_o}, 32'd1);
    chk("b2b first resultado", resultado_o, 32'h00000003);
    chk("b2b concl pronto", {31'd0, req_pronto_o}, 32'd0);
    @(negedge clock_i);
    chk("b2b idle pronto", {31'd0, req_pronto_o}, 32'd1);
    chk("b2b idle valido", {31'd0, resultado_valido_o}, 32'd0);
    chk("b2b idle resultado", resultado_o, 32'h00000003);
    @(negedge clock_i);
    req_valido_i = 1'b0;
    chk("b2b second accepted", {31'd0, ocupado_o}, 32'd1);
    chk("b2b second pronto", {31'd0, req_pronto_o}, 32'd0);
    @(negedge clock_i);
    chk("b2b second early", {31'd0, resultado_valido_o}, 32'd0);
    @(negedge clock_i);
    chk("b2b second valido", {31'd0, resultado_valido_o}, 32'd1);
    chk("b2b second resultado", resultado_o, 32'h00000010);
    @(negedge clock_i);

    // SLL 1 by 31 aborted by reset sampled at the 3rd shift edge.
    @(negedge clock_i);
    req_valido_i = 1'b1;
    operando_i   = 32'h00000001;
    quantidade_i = 5'd31;
    tipo_i       = 2'b00;
    @(negedge clock_i);
    req_valido_i = 1'b0;
    @(negedge clock_i);
    @(negedge clock_i);
    chk("abort intermediate", resultado_o, 32'h00000004);
    reset_i = 1'b0;
    @(negedge clock_i);
    chk("abort resultado", resultado_o, 32'h0);
    chk("abort valido", {31'd0, resultado_valido_o}, 32'd0);
    chk("abort ocupado", {31'd0, ocupado_o}, 32'd0);
    chk("abort pronto", {31'd0, req_pronto_o}, 32'd0);
    reset_i = 1'b1;
    #1;
    chk("abort release pronto", {31'd0, req_pronto_o}, 32'd1);
    for (int k = 0; k < 35; k++) begin
      @(negedge clock_i);
      if (resultado_valido_o) begin
        chk("abort no pulse", {31'd0, resultado_valido_o}, 32'd0);
      end
    end
    chk("abort stays idle", {31'd0, ocupado_o}, 32'd0);

    // Full-amount job after the abort still works.
    job(99, 2'b01, 32'hFFFFFFFF, 5'd31, 32'h00000001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
